ref_cline_req_sequencer: RTL and testbench

- Sits directly downstream of the per-block cache-line span calculator in the reference-cache fetch path.
- Takes one reference-block request (start position plus cache-line span deltas) and walks every covered cache line in raster order.
- Emits one cache-line coordinate per cycle towards the tag-lookup stage over a valid/ready handshake.
- Provides block-level accept backpressure and a completion pulse.

---
 rtl/ref_cline_req_sequencer_if.sv | 55 +++++
 rtl/ref_cline_req_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_ref_cline_req_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ref_cline_req_sequencer_if.sv
// ---------------------------------------------------------------------------
// ref_cline_req_sequencer_if
// Bundles the block-request input side and the cache-line request output
// side of the reference-cache line sequencer.
//
//   Block side : blk_valid_in, blk_ready_out, start_x_in, start_y_in,
//                delta_x_in, delta_y_in, flush_in
//   Line side  : cl_valid_out, cl_ready_in, cl_x_out, cl_y_out, cl_idx_out,
//                cl_first_out, cl_last_out, blk_done_out
//
// Modports:
//   slave  - the sequencer itself (consumes blocks, produces line requests)
//   master - the environment around it (span calculator upstream plus the
//            tag-lookup stage downstream)
// ---------------------------------------------------------------------------
interface ref_cline_req_sequencer_if #(
   parameter int C_L_H_SIZE = 3,
   parameter int C_L_V_SIZE = 2,
   parameter int PIC_X_WDTH = 12,
   parameter int PIC_Y_WDTH = 12
);
   localparam int CLX_WDTH = PIC_X_WDTH - C_L_H_SIZE;
   localparam int CLY_WDTH = PIC_Y_WDTH - C_L_V_SIZE;

   logic                  blk_valid_in;
   logic                  blk_ready_out;
   logic [PIC_X_WDTH-1:0] start_x_in;
   logic [PIC_Y_WDTH-1:0] start_y_in;
   logic [1:0]            delta_x_in;
   logic [1:0]            delta_y_in;
   logic                  flush_in;

   logic                  cl_valid_out;
   logic                  cl_ready_in;
   logic [CLX_WDTH-1:0]   cl_x_out;
   logic [CLY_WDTH-1:0]   cl_y_out;
   logic [3:0]            cl_idx_out;
   logic                  cl_first_out;
   logic                  cl_last_out;
   logic                  blk_done_out;

   modport slave (
      input  blk_valid_in, start_x_in, start_y_in, delta_x_in, delta_y_in,
             flush_in, cl_ready_in,
      output blk_ready_out, cl_valid_out, cl_x_out, cl_y_out, cl_idx_out,
             cl_first_out, cl_last_out, blk_done_out
   );

   modport master (
      output blk_valid_in, start_x_in, start_y_in, delta_x_in, delta_y_in,
             flush_in, cl_ready_in,
      input  blk_ready_out, cl_valid_out, cl_x_out, cl_y_out, cl_idx_out,
             cl_first_out, cl_last_out, blk_done_out
   );
endinterface

// File: rtl/ref_cline_req_sequencer.sv
// ---------------------------------------------------------------------------
// ref_cline_req_sequencer
// Accepts one reference-block request (start pixel position plus cache-line
// span deltas) and walks every covered cache line in raster order (x inner,
// y outer), issuing one registered line coordinate per cycle over a
// valid/ready handshake. A new block can be accepted in the same cycle as
// the last line transfer, so consecutive blocks stream without a bubble.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset
//   bus    - slave view of ref_cline_req_sequencer_if (block request in,
//            cache-line request out, flush, done pulse)
// ---------------------------------------------------------------------------
module ref_cline_req_sequencer #(
   parameter int C_L_H_SIZE = 3,
   parameter int C_L_V_SIZE = 2,
   parameter int PIC_X_WDTH = 12,
   parameter int PIC_Y_WDTH = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   ref_cline_req_sequencer_if.slave bus
);
   localparam int CLX_WDTH = PIC_X_WDTH - C_L_H_SIZE;
   localparam int CLY_WDTH = PIC_Y_WDTH - C_L_V_SIZE;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t              state_q, state_d;

   logic [CLX_WDTH-1:0] base_x_q, base_x_d;
   logic [CLY_WDTH-1:0] base_y_q, base_y_d;
   logic [1:0]          dx_q, dx_d;
   logic [1:0]          dy_q, dy_d;
   logic [1:0]          cnt_x_q, cnt_x_d;
   logic [1:0]          cnt_y_q, cnt_y_d;

   logic                cl_valid_q, cl_valid_d;
   logic [CLX_WDTH-1:0] cl_x_q, cl_x_d;
   logic [CLY_WDTH-1:0] cl_y_q, cl_y_d;
   logic [3:0]          cl_idx_q, cl_idx_d;
   logic                cl_first_q, cl_first_d;
   logic                cl_last_q, cl_last_d;
   logic                blk_done_q, blk_done_d;

   logic                xfer;
   logic                last_xfer;
   logic                blk_ready;
   logic                accept;
   logic [1:0]          nx, ny;

   // Line coordinates wrap silently at the picture-index width.
   function automatic logic [CLX_WDTH-1:0] line_x(input logic [CLX_WDTH-1:0] base,
                                                  input logic [1:0] off);
      return base + CLX_WDTH'(off);
   endfunction

   function automatic logic [CLY_WDTH-1:0] line_y(input logic [CLY_WDTH-1:0] base,
                                                  input logic [1:0] off);
      return base + CLY_WDTH'(off);
   endfunction

   // Handshake decode. Ready is held low while in reset and during a flush
   // cycle; in ISSUE it only opens on the last-line transfer so the next
   // block slots in with no idle cycle.
   always_comb begin
      xfer      = cl_valid_q & bus.cl_ready_in;
      last_xfer = xfer & cl_last_q;
      blk_ready = 1'b0;
      if (reset && !bus.flush_in)
         blk_ready = (state_q == IDLE) ? 1'b1 : last_xfer;
      accept    = bus.blk_valid_in & blk_ready;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (bus.flush_in)
         state_d = IDLE;
      else if (accept)
         state_d = ISSUE;
      else if (last_xfer)
         state_d = IDLE;
   end

   // Next values of the latched block fields, counters and registered outputs
   always_comb begin
      base_x_d   = base_x_q;
      base_y_d   = base_y_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      cnt_x_d    = cnt_x_q;
      cnt_y_d    = cnt_y_q;
      cl_valid_d = cl_valid_q;
      cl_x_d     = cl_x_q;
      cl_y_d     = cl_y_q;
      cl_idx_d   = cl_idx_q;
      cl_first_d = cl_first_q;
      cl_last_d  = cl_last_q;
      blk_done_d = 1'b0;
      nx         = 2'd0;
      ny         = 2'd0;

      if (bus.flush_in) begin
         cnt_x_d    = 2'd0;
         cnt_y_d    = 2'd0;
         cl_valid_d = 1'b0;
         cl_idx_d   = 4'd0;
         cl_first_d = 1'b0;
         cl_last_d  = 1'b0;
      end else begin
         blk_done_d = last_xfer;
         if (accept) begin
            base_x_d   = CLX_WDTH'(bus.start_x_in >> C_L_H_SIZE);
            base_y_d   = CLY_WDTH'(bus.start_y_in >> C_L_V_SIZE);
            dx_d       = bus.delta_x_in;
            dy_d       = bus.delta_y_in;
            cnt_x_d    = 2'd0;
            cnt_y_d    = 2'd0;
            cl_valid_d = 1'b1;
            cl_x_d     = CLX_WDTH'(bus.start_x_in >> C_L_H_SIZE);
            cl_y_d     = CLY_WDTH'(bus.start_y_in >> C_L_V_SIZE);
            cl_idx_d   = 4'd0;
            cl_first_d = 1'b1;
            cl_last_d  = (bus.delta_x_in == 2'd0) && (bus.delta_y_in == 2'd0);
         end else if (last_xfer) begin
            cnt_x_d    = 2'd0;
            cnt_y_d    = 2'd0;
            cl_valid_d = 1'b0;
            cl_idx_d   = 4'd0;
            cl_first_d = 1'b0;
            cl_last_d  = 1'b0;
         end else if (xfer) begin
            if (cnt_x_q == dx_q) begin
               nx = 2'd0;
               ny = cnt_y_q + 2'd1;
            end else begin
               nx = cnt_x_q + 2'd1;
               ny = cnt_y_q;
            end
            cnt_x_d    = nx;
            cnt_y_d    = ny;
            cl_x_d     = line_x(base_x_q, nx);
            cl_y_d     = line_y(base_y_q, ny);
            // Raster order makes cnt_y*(dx+1)+cnt_x equal to the running
            // line count, so the ordinal simply increments per transfer.
            cl_idx_d   = cl_idx_q + 4'd1;
            cl_first_d = 1'b0;
            cl_last_d  = (nx == dx_q) && (ny == dy_q);
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         base_x_q   <= '0;
         base_y_q   <= '0;
         dx_q       <= 2'd0;
         dy_q       <= 2'd0;
         cnt_x_q    <= 2'd0;
         cnt_y_q    <= 2'd0;
         cl_valid_q <= 1'b0;
         cl_x_q     <= '0;
         cl_y_q     <= '0;
         cl_idx_q   <= 4'd0;
         cl_first_q <= 1'b0;
         cl_last_q  <= 1'b0;
         blk_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_x_q   <= base_x_d;
         base_y_q   <= base_y_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         cnt_x_q    <= cnt_x_d;
         cnt_y_q    <= cnt_y_d;
         cl_valid_q <= cl_valid_d;
         cl_x_q     <= cl_x_d;
         cl_y_q     <= cl_y_d;
         cl_idx_q   <= cl_idx_d;
         cl_first_q <= cl_first_d;
         cl_last_q  <= cl_last_d;
         blk_done_q <= blk_done_d;
      end
   end

   assign bus.blk_ready_out = blk_ready;
   assign bus.cl_valid_out  = cl_valid_q;
   assign bus.cl_x_out      = cl_x_q;
   assign bus.cl_y_out      = cl_y_q;
   assign bus.cl_idx_out    = cl_idx_q;
   assign bus.cl_first_out  = cl_first_q;
   assign bus.cl_last_out   = cl_last_q;
   assign bus.blk_done_out  = blk_done_q;

endmodule

// File: tb/tb_ref_cline_req_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ref_cline_req_sequencer
// Directed scenarios followed by randomized traffic. A queue-based reference
// model expands each accepted block into its list of expected cache lines and
// tracks the expected done pulse and block-ready level cycle by cycle.
// ---------------------------------------------------------------------------
module tb_ref_cline_req_sequencer;
   localparam int C_L_H_SIZE = 3;
   localparam int C_L_V_SIZE = 2;
   localparam int PIC_X_WDTH = 12;
   localparam int PIC_Y_WDTH = 12;
   localparam int CLX_WDTH   = PIC_X_WDTH - C_L_H_SIZE;
   localparam int CLY_WDTH   = PIC_Y_WDTH - C_L_V_SIZE;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   ref_cline_req_sequencer_if #(
      .C_L_H_SIZE(C_L_H_SIZE), .C_L_V_SIZE(C_L_V_SIZE),
      .PIC_X_WDTH(PIC_X_WDTH), .PIC_Y_WDTH(PIC_Y_WDTH)
   ) bus ();

   ref_cline_req_sequencer #(
      .C_L_H_SIZE(C_L_H_SIZE), .C_L_V_SIZE(C_L_V_SIZE),
      .PIC_X_WDTH(PIC_X_WDTH), .PIC_Y_WDTH(PIC_Y_WDTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int x;
      int y;
      int idx;
      bit first;
      bit last;
   } line_t;

   line_t exp_q[$];
   bit    done_exp  = 1'b0;
   int    n_checks  = 0;
   int    n_errors  = 0;
   int    done_seen = 0;
   int    lx[$];
   int    ly[$];
   int    lidx[$];

   int t1x[6] = '{1, 2, 1, 2, 1, 2};
   int t1y[6] = '{1, 1, 2, 2, 3, 3};
   int twx[3] = '{511, 0, 1};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Expand one block into its full raster-ordered line list.
   task automatic push_block(input int sx, input int sy, input int dx, input int dy);
      int bx;
      int by;
      bx = sx / (1 << C_L_H_SIZE);
      by = sy / (1 << C_L_V_SIZE);
      for (int j = 0; j <= dy; j++) begin
         for (int i = 0; i <= dx; i++) begin
            line_t l;
            l.x     = (bx + i) % (1 << CLX_WDTH);
            l.y     = (by + j) % (1 << CLY_WDTH);
            l.idx   = j * (dx + 1) + i;
            l.first = (i == 0) && (j == 0);
            l.last  = (i == dx) && (j == dy);
            exp_q.push_back(l);
         end
      end
   endtask

   task automatic clr_log();
      lx.delete();
      ly.delete();
      lidx.delete();
      done_seen = 0;
   endtask

   // One clock cycle: drive inputs after the edge, check at the falling edge,
   // then advance the model to what the next rising edge should produce.
   task automatic cyc(input bit bv, input int sx, input int sy, input int dx,
                      input int dy, input bit fl, input bit rdy);
      bit exp_rdy;
      @(posedge clk);
      #1;
      bus.blk_valid_in = bv;
      bus.start_x_in   = PIC_X_WDTH'(sx);
      bus.start_y_in   = PIC_Y_WDTH'(sy);
      bus.delta_x_in   = 2'(dx);
      bus.delta_y_in   = 2'(dy);
      bus.flush_in     = fl;
      bus.cl_ready_in  = rdy;
      @(negedge clk);
      exp_rdy = !fl && ((exp_q.size() == 0) || (rdy && exp_q.size() == 1));
      chk("cl_valid", 64'(bus.cl_valid_out), 64'(exp_q.size() > 0));
      chk("blk_ready", 64'(bus.blk_ready_out), 64'(exp_rdy));
      chk("blk_done", 64'(bus.blk_done_out), 64'(done_exp));
      if (bus.blk_done_out === 1'b1) done_seen++;
      if (exp_q.size() > 0) begin
         chk("cl_x", 64'(bus.cl_x_out), 64'(exp_q[0].x));
         chk("cl_y", 64'(bus.cl_y_out), 64'(exp_q[0].y));
         chk("cl_idx", 64'(bus.cl_idx_out), 64'(exp_q[0].idx));
         chk("cl_first", 64'(bus.cl_first_out), 64'(exp_q[0].first));
         chk("cl_last", 64'(bus.cl_last_out), 64'(exp_q[0].last));
      end
      done_exp = 1'b0;
      if (fl) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() > 0 && rdy) begin
            lx.push_back(int'(bus.cl_x_out));
            ly.push_back(int'(bus.cl_y_out));
            lidx.push_back(int'(bus.cl_idx_out));
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) done_exp = 1'b1;
         end
         if (bv && exp_rdy) push_block(sx, sy, dx, dy);
      end
   endtask

   initial begin
      bus.blk_valid_in = 1'b0;
      bus.start_x_in   = '0;
      bus.start_y_in   = '0;
      bus.delta_x_in   = 2'd0;
      bus.delta_y_in   = 2'd0;
      bus.flush_in     = 1'b0;
      bus.cl_ready_in  = 1'b0;

      // Reset state
      #2;
      chk("rst_valid", 64'(bus.cl_valid_out), 64'd0);
      chk("rst_ready", 64'(bus.blk_ready_out), 64'd0);
      chk("rst_done", 64'(bus.blk_done_out), 64'd0);
      chk("rst_idx", 64'(bus.cl_idx_out), 64'd0);
      chk("rst_first", 64'(bus.cl_first_out), 64'd0);
      chk("rst_last", 64'(bus.cl_last_out), 64'd0);
      chk("rst_x", 64'(bus.cl_x_out), 64'd0);
      #21 reset = 1'b1;

      // Basic 2x3 block at full throughput
      clr_log();
      cyc(1, 13, 6, 1, 2, 0, 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, 1);
      chk("t1_count", 64'(lx.size()), 64'd6);
      for (int i = 0; i < 6 && i < lx.size(); i++) begin
         chk("t1_x", 64'(lx[i]), 64'(t1x[i]));
         chk("t1_y", 64'(ly[i]), 64'(t1y[i]));
         chk("t1_idx", 64'(lidx[i]), 64'(i));
      end
      chk("t1_done_cnt", 64'(done_seen), 64'd1);

      // Same block with downstream stalls
      clr_log();
      cyc(1, 13, 6, 1, 2, 0, 0);
      for (int i = 0; i < 30 && lx.size() < 6; i++) cyc(0, 0, 0, 0, 0, 0, (i % 3) == 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("t2_count", 64'(lx.size()), 64'd6);
      for (int i = 0; i < 6 && i < lx.size(); i++) begin
         chk("t2_x", 64'(lx[i]), 64'(t1x[i]));
         chk("t2_y", 64'(ly[i]), 64'(t1y[i]));
      end
      chk("t2_done_cnt", 64'(done_seen), 64'd1);

      // Column index wrap
      clr_log();
      cyc(1, 4092, 100, 2, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1);
      chk("wrap_count", 64'(lx.size()), 64'd3);
      for (int i = 0; i < 3 && i < lx.size(); i++) begin
         chk("wrap_x", 64'(lx[i]), 64'(twx[i]));
         chk("wrap_y", 64'(ly[i]), 64'd25);
      end

      // Back-to-back blocks: second block held valid through the first
      clr_log();
      cyc(1, 0, 0, 1, 1, 0, 1);
      for (int i = 0; i < 4; i++) cyc(1, 64, 32, 0, 1, 0, 1);
      chk("b2b_done_a", 64'(done_seen), 64'd0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
      chk("b2b_count", 64'(lx.size()), 64'd6);
      if (lx.size() == 6) begin
         chk("b2b_x4", 64'(lx[4]), 64'd8);
         chk("b2b_y5", 64'(ly[5]), 64'd9);
         chk("b2b_idx4", 64'(lidx[4]), 64'd0);
      end
      chk("b2b_done_cnt", 64'(done_seen), 64'd2);

      // Single-line block, then a full 4x4 block
      clr_log();
      cyc(1, 40, 40, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("single_count", 64'(lx.size()), 64'd1);
      clr_log();
      cyc(1, 100, 200, 3, 3, 0, 1);
      for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0, 0, 0, 1);
      chk("full_count", 64'(lidx.size()), 64'd16);
      for (int i = 0; i < 16 && i < lidx.size(); i++) chk("full_idx", 64'(lidx[i]), 64'(i));

      // Flush on the third line of a 12-line block, new block offered throughout
      clr_log();
      cyc(1, 0, 0, 3, 2, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(1, 8, 8, 1, 0, 1, 1);
      cyc(1, 64, 64, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
      chk("flush_count", 64'(lx.size()), 64'd4);
      if (lx.size() == 4) begin
         chk("flush_new_x", 64'(lx[2]), 64'd8);
         chk("flush_new_idx", 64'(lidx[2]), 64'd0);
      end
      chk("flush_done_cnt", 64'(done_seen), 64'd1);

      // Asynchronous reset in the middle of a block
      clr_log();
      cyc(1, 0, 0, 3, 3, 0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
      @(posedge clk);
      #3;
      bus.blk_valid_in = 1'b0;
      reset = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.cl_valid_out), 64'd0);
      chk("arst_ready", 64'(bus.blk_ready_out), 64'd0);
      chk("arst_done", 64'(bus.blk_done_out), 64'd0);
      chk("arst_idx", 64'(bus.cl_idx_out), 64'd0);
      chk("arst_first", 64'(bus.cl_first_out), 64'd0);
      exp_q.delete();
      done_exp = 1'b0;
      #20 reset = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("arst_ready_after", 64'(bus.blk_ready_out), 64'd1);
      cyc(0, 0, 0, 0, 0, 0, 1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         cyc($urandom_range(0, 1) == 1,
             int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
